// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
// Shares one serial engine between two requesters (clock-chip controller = 0,
// AFE controller = 1). Each requester gets a one-deep holding register; a
// round-robin arbiter picks a winner whenever the engine is idle, launches it,
// follows the engine's ready handshake and releases the grant afterwards.
//
// Request handshake: reqN_ready high means requester N may pulse reqN_start.
// A pulse seen while reqN_ready is high is accepted on that edge and the
// data word is latched. A pulse seen while reqN_ready is low is dropped.
// reqN_ready stays low until that requester's transaction has been released.
//
// Engine handshake: engine_start pulses for one cycle with engine_data and
// engine_select already stable; the engine acknowledges by dropping
// engine_ready and signals completion by raising it again.
module serial_bus_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ENGINE_TIMEOUT = 4095
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0_start,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req1_start,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req0_ready,
   output logic                  req1_ready,
   input  logic                  engine_ready,
   output logic                  engine_start,
   output logic [DATA_WIDTH-1:0] engine_data,
   output logic                  engine_select,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RELEASE   = 3'd4
   } state_t;

   localparam logic [11:0] TMO_LIMIT = 12'(ENGINE_TIMEOUT);

   state_t                state;
   state_t                state_nxt;
   logic                  pending0;
   logic                  pending1;
   logic [DATA_WIDTH-1:0] hold0;
   logic [DATA_WIDTH-1:0] hold1;
   logic                  last_served;
   logic                  granted_id;
   logic [11:0]           tmo_cnt;

   logic                  arb_go;
   logic                  arb_win;
   logic                  tmo_hit;
   logic                  take0;
   logic                  take1;
   logic                  clr0;
   logic                  clr1;

   // Requests are accepted only while the requester's slot is empty.
   assign take0 = req0_start & ~pending0;
   assign take1 = req1_start & ~pending1;

   // The granted slot empties on the release cycle.
   assign clr0 = (state == S_RELEASE) & ~granted_id;
   assign clr1 = (state == S_RELEASE) &  granted_id;

   assign req0_ready   = ~pending0;
   assign req1_ready   = ~pending1;
   assign engine_start = (state == S_LAUNCH);
   assign busy         = (state != S_IDLE);

   // Next-state and arbitration decode.
   always_comb begin
      state_nxt = state;
      arb_go    = 1'b0;
      tmo_hit   = 1'b0;
      // Round-robin: with both pending, the one not served last wins.
      arb_win   = (pending0 & pending1) ? ~last_served : pending1;
      case (state)
         S_IDLE: begin
            if ((pending0 | pending1) & engine_ready) begin
               arb_go    = 1'b1;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (tmo_cnt == TMO_LIMIT) begin
               tmo_hit   = 1'b1;
               state_nxt = S_RELEASE;
            end else if (!engine_ready) begin
               state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (tmo_cnt == TMO_LIMIT) begin
               tmo_hit   = 1'b1;
               state_nxt = S_RELEASE;
            end else if (engine_ready) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Per-requester pending flags and holding registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending0 <= 1'b0;
         pending1 <= 1'b0;
         hold0    <= '0;
         hold1    <= '0;
      end else begin
         if (take0) begin
            pending0 <= 1'b1;
            hold0    <= req0_data;
         end else if (clr0) begin
            pending0 <= 1'b0;
         end
         if (take1) begin
            pending1 <= 1'b1;
            hold1    <= req1_data;
         end else if (clr1) begin
            pending1 <= 1'b0;
         end
      end
   end

   // Grant, engine word/steering and round-robin history.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grant         <= 2'b00;
         granted_id    <= 1'b0;
         last_served   <= 1'b1;
         engine_data   <= '0;
         engine_select <= 1'b0;
      end else if (arb_go) begin
         grant         <= arb_win ? 2'b10 : 2'b01;
         granted_id    <= arb_win;
         engine_data   <= arb_win ? hold1 : hold0;
         engine_select <= arb_win;
      end else if (state == S_RELEASE) begin
         grant         <= 2'b00;
         last_served   <= granted_id;
      end
   end

   // Engine watchdog: restarts on launch, runs while waiting on the engine.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo_hit;
         if (state == S_LAUNCH) begin
            tmo_cnt <= '0;
         end else if ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) begin
            tmo_cnt <= tmo_cnt + 12'd1;
         end
      end
   end

endmodule
